sliding_threshold_detector: RTL and testbench

- Downstream consumer of the sliding-average stage. Takes the signed average stream and detects crossings of programmable high/low thresholds with hysteresis.
- A crossing counts only after HOLD consecutive qualifying samples (debounce).
- Outputs a registered level and a one-entry event slot with valid/ready handshake, read by control/status logic.

---
 rtl/sliding_threshold_detector_pkg.sv | 18 +
 rtl/sliding_threshold_detector_if.sv | 27 ++
 rtl/sliding_event_slot.sv | 34 +++
 rtl/sliding_threshold_detector.sv | 129 ++++++++++++
 tb/tb_sliding_threshold_detector.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sliding_threshold_detector_pkg.sv
// Shared types for the sliding-average threshold detector: FSM state encoding,
// the event record held by the output slot, and the debounce length ceiling.
package sliding_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    RISING  = 2'd1,
    HIGH    = 2'd2,
    FALLING = 2'd3
  } state_e;

  typedef struct packed {
    logic rise;
  } evt_t;

  localparam int HOLD_MAX = 255;

endpackage

// File: rtl/sliding_threshold_detector_if.sv
// Sample stream, live thresholds, debounced level and the event handshake
// between the sliding-average stage, the detector and control/status logic.
interface sliding_threshold_detector_if #(
  parameter int WIDTH = 8
);

  logic                    in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic signed [WIDTH-1:0] thr_high;
  logic signed [WIDTH-1:0] thr_low;
  logic                    level;
  logic                    evt_valid;
  logic                    evt_rise;
  logic                    evt_ready;
  logic                    evt_overrun;

  modport master (
    output in_valid, in_data, thr_high, thr_low, evt_ready,
    input  level, evt_valid, evt_rise, evt_overrun
  );

  modport slave (
    input  in_valid, in_data, thr_high, thr_low, evt_ready,
    output level, evt_valid, evt_rise, evt_overrun
  );

endinterface

// File: rtl/sliding_event_slot.sv
// One-entry event buffer: a push always wins and overwrites, flagging overrun
// only when the old event was still pending and not being taken this cycle.
module sliding_event_slot
  import sliding_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  evt_t push_evt,
  input  logic ready,
  output logic valid,
  output evt_t evt,
  output logic overrun
);

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid   <= 1'b0;
      evt     <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && valid && !ready;
      if (push) begin
        valid <= 1'b1;
        evt   <= push_evt;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sliding_threshold_detector.sv
// Hysteresis threshold detector with HOLD-sample debounce on the averaged
// stream; emits a registered level and rise/fall events through a one-entry slot.
module sliding_threshold_detector
  import sliding_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HOLD  = 4   // legal range 1..HOLD_MAX
) (
  input logic clk,
  input logic reset,
  sliding_threshold_detector_if.slave bus
);

  localparam int CNT_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic signed [WIDTH-1:0] data;
  logic signed [WIDTH-1:0] thr_high;
  logic signed [WIDTH-1:0] thr_low;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_q;
  logic             qual;
  logic             push;
  evt_t             push_evt;
  evt_t             slot_evt;

  assign data     = bus.in_data;
  assign thr_high = bus.thr_high;
  assign thr_low  = bus.thr_low;

  // Low side looks for a climb above thr_high, high side for a drop below thr_low.
  assign qual = (state == LOW || state == RISING) ? (data > thr_high)
                                                  : (data < thr_low);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    push          = 1'b0;
    push_evt.rise = 1'b0;
    if (bus.in_valid) begin
      unique case (state)
        LOW: begin
          if (qual) begin
            if (HOLD == 1) begin
              state_n       = HIGH;
              push          = 1'b1;
              push_evt.rise = 1'b1;
            end else begin
              state_n = RISING;
              cnt_n   = ONE_C;
            end
          end
        end
        RISING: begin
          if (!qual) begin
            state_n = LOW;
            cnt_n   = '0;
          end else if (cnt + ONE_C == HOLD_C) begin
            state_n       = HIGH;
            cnt_n         = '0;
            push          = 1'b1;
            push_evt.rise = 1'b1;
          end else begin
            cnt_n = cnt + ONE_C;
          end
        end
        HIGH: begin
          if (qual) begin
            if (HOLD == 1) begin
              state_n = LOW;
              push    = 1'b1;
            end else begin
              state_n = FALLING;
              cnt_n   = ONE_C;
            end
          end
        end
        FALLING: begin
          if (!qual) begin
            state_n = HIGH;
            cnt_n   = '0;
          end else if (cnt + ONE_C == HOLD_C) begin
            state_n = LOW;
            cnt_n   = '0;
            push    = 1'b1;
          end else begin
            cnt_n = cnt + ONE_C;
          end
        end
        default: begin
          state_n = LOW;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= LOW;
      cnt     <= '0;
      level_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      level_q <= (state_n == HIGH) || (state_n == FALLING);
    end
  end

  sliding_event_slot u_slot (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_evt (push_evt),
    .ready    (bus.evt_ready),
    .valid    (bus.evt_valid),
    .evt      (slot_evt),
    .overrun  (bus.evt_overrun)
  );

  assign bus.level    = level_q;
  assign bus.evt_rise = slot_evt.rise;

endmodule

// File: tb/tb_sliding_threshold_detector.sv
// Directed and randomized checks of the threshold detector against a
// run-length model of debounced hysteresis and a one-entry event slot.
module tb_sliding_threshold_detector;

  localparam int WIDTH = 8;
  localparam int HOLD  = 4;

  logic clk    = 1'b0;
  logic clk_en = 1'b1;
  logic reset  = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_run;
  bit m_level, m_valid, m_rise, m_ovr;

  sliding_threshold_detector_if #(.WIDTH(WIDTH)) bus ();

  sliding_threshold_detector #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  function automatic logic [3:0] dut_vec();
    return {bus.level, bus.evt_valid, bus.evt_rise, bus.evt_overrun};
  endfunction

  function automatic logic [3:0] mdl_vec();
    return {m_level, m_valid, m_rise, m_ovr};
  endfunction

  task automatic m_clear();
    m_run = 0; m_level = 0; m_valid = 0; m_rise = 0; m_ovr = 0;
  endtask

  task automatic set_thr(input int hi, input int lo);
    bus.thr_high = WIDTH'(hi);
    bus.thr_low  = WIDTH'(lo);
  endtask

  // Drive one cycle, advance the model at the edge, leave time at edge+1.
  task automatic step(input bit v, input int d, input bit r);
    bit new_evt;
    bit q;
    int hi, lo;
    bus.in_valid  = v;
    bus.in_data   = WIDTH'(d);
    bus.evt_ready = r;
    @(posedge clk);
    hi = int'(bus.thr_high);
    lo = int'(bus.thr_low);
    new_evt = 0;
    m_ovr   = 0;
    if (v) begin
      q = m_level ? (d < lo) : (d > hi);
      m_run = q ? m_run + 1 : 0;
      if (m_run == HOLD) begin
        m_level = !m_level;
        m_run   = 0;
        new_evt = 1;
      end
    end
    if (new_evt) begin
      m_ovr   = m_valid && !r;
      m_valid = 1;
      m_rise  = m_level;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 0; bus.in_data = '0; bus.evt_ready = 0;
    set_thr(20, -20);
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 4'b0000) begin
      errors++; $display("FAIL reset_held got %b want 0000", dut_vec());
    end
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0);
    checks++;
    if (dut_vec() !== 4'b0000) begin
      errors++; $display("FAIL reset_release got %b want 0000", dut_vec());
    end
    clk_en = 1'b0;
    #20;
    reset = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 4'b0000) begin
      errors++; $display("FAIL reset_noclk got %b want 0000", dut_vec());
    end
    #5;
    reset  = 1'b1;
    #5;
    clk_en = 1'b1;
  endtask

  task automatic test_rise_with_gaps();
    for (int i = 0; i < HOLD; i++) begin
      step(1, 25, 0);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL rise_sample%0d got %b want %b", i, dut_vec(), mdl_vec());
      end
      if (i != HOLD - 1) begin
        step(0, 0, 0);
        step(0, -100, 0);
      end
    end
    checks++;
    if ({bus.level, bus.evt_valid, bus.evt_rise} !== 3'b111) begin
      errors++; $display("FAIL rise_event got %b want 111", {bus.level, bus.evt_valid, bus.evt_rise});
    end
    step(0, 0, 1);
    checks++;
    if (bus.evt_valid !== 1'b0 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL rise_handshake got %b want %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_debounce_reset();
    int seq[7] = '{25, 25, 25, 10, 25, 25, 25};
    for (int i = 0; i < HOLD; i++) step(1, -30, 1);
    checks++;
    if (dut_vec() !== mdl_vec() || bus.level !== 1'b0) begin
      errors++; $display("FAIL debounce_fall got %b want %b", dut_vec(), mdl_vec());
    end
    for (int i = 0; i < 7; i++) begin
      step(1, seq[i], 1);
      checks++;
      if (dut_vec() !== mdl_vec() || bus.level !== 1'b0) begin
        errors++; $display("FAIL debounce_seq%0d got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    step(1, 25, 1);
    checks++;
    if (bus.level !== 1'b1 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL debounce_rise got %b want %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_threshold_equal();
    for (int i = 0; i < HOLD; i++) step(1, -30, 1);
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 20, 1);
    checks++;
    if (bus.level !== 1'b0 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL equal_high got %b want level 0", dut_vec());
    end
    for (int i = 0; i < HOLD; i++) step(1, 25, 1);
    for (int i = 0; i < 6; i++) step(1, -20, 1);
    checks++;
    if (bus.level !== 1'b1 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL equal_low got %b want level 1", dut_vec());
    end
    for (int i = 0; i < HOLD; i++) step(1, -21, 1);
    checks++;
    if ({bus.level, bus.evt_valid, bus.evt_rise} !== 3'b010 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL equal_fall got %b want %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_overrun();
    int pulses = 0;
    step(0, 0, 1);
    for (int i = 0; i < HOLD; i++) begin
      step(1, 25, 0);
      pulses += int'(bus.evt_overrun);
    end
    checks++;
    if ({bus.level, bus.evt_valid, bus.evt_rise} !== 3'b111) begin
      errors++; $display("FAIL overrun_rise got %b want 111", {bus.level, bus.evt_valid, bus.evt_rise});
    end
    for (int i = 0; i < HOLD; i++) begin
      step(1, -30, 0);
      pulses += int'(bus.evt_overrun);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL overrun_fall%0d got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if ({bus.level, bus.evt_valid, bus.evt_rise} !== 3'b010) begin
      errors++; $display("FAIL overrun_slot got %b want 010", {bus.level, bus.evt_valid, bus.evt_rise});
    end
    step(0, 0, 0);
    pulses += int'(bus.evt_overrun);
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL overrun_count got %0d want 1", pulses);
    end
  endtask

  task automatic test_async_reset_midcount();
    for (int i = 0; i < HOLD - 1; i++) step(1, 25, 0);
    checks++;
    if (dut_vec() !== mdl_vec() || bus.evt_valid !== 1'b1) begin
      errors++; $display("FAIL midcount_pre got %b want %b", dut_vec(), mdl_vec());
    end
    clk_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 4'b0000) begin
      errors++; $display("FAIL midcount_reset got %b want 0000", dut_vec());
    end
    m_clear();
    #10;
    reset  = 1'b1;
    #3;
    clk_en = 1'b1;
    step(1, 25, 0);
    checks++;
    if (bus.level !== 1'b0 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL midcount_one got %b want %b", dut_vec(), mdl_vec());
    end
    for (int i = 0; i < HOLD - 1; i++) step(1, 25, 0);
    checks++;
    if ({bus.level, bus.evt_valid, bus.evt_rise} !== 3'b111 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL midcount_four got %b want %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_random();
    int d;
    bit v, r;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0)
        set_thr(int'($urandom_range(0, 60)) - 30, int'($urandom_range(0, 60)) - 30);
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 1) == 1;
      d = ($urandom_range(0, 4) == 0) ? int'(bus.thr_high)
                                      : int'($urandom_range(0, 100)) - 50;
      step(v, d, r);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL random_cycle%0d got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise_with_gaps();
    test_debounce_reset();
    test_threshold_equal();
    test_overrun();
    test_async_reset_midcount();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
